// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: registered N-to-2^N one-hot decoder with handshaked direct decode and self-stepping scan mode.
// Optional DEC_SCAN_BLANK_EN inserts one blank (all-zero) cycle between scan steps.
module decoder_scan_seq #(
  parameter int N = 3,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap
);
  localparam int OUTW = 2**N;
  localparam int CW = $clog2(HOLD) + 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);
  localparam logic [OUTW-1:0] ONE = OUTW'(1);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [OUTW-1:0] y_nxt;
  logic [N-1:0] idx_nxt, idx_inc;
  logic wrap_nxt, step, xfer;
  // Gated by rst_n so the handshake is closed while reset is asserted.
  assign x_ready = rst_n & en & ~mode;
  assign xfer = x_valid & x_ready;
  assign idx_inc = idx + 1'b1;
`ifdef DEC_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK = CW'(HOLD);
  assign step = cnt == BLANK;
`else
  assign step = cnt == LAST;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      y <= '0;
      idx <= '0;
      wrap <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      y <= y_nxt;
      idx <= idx_nxt;
      wrap <= wrap_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = !en ? IDLE : mode ? SCAN : DIRECT;
    y_nxt = y;
    idx_nxt = idx;
    cnt_nxt = '0;
    wrap_nxt = 1'b0;
    if (state_nxt == IDLE)
      y_nxt = '0;
    else if (state_nxt == DIRECT) begin
      if (xfer) begin
        y_nxt = ONE << x_in;
        idx_nxt = x_in;
      end
    end else if (state != SCAN)
      y_nxt = ONE << idx;
    else if (step) begin
      idx_nxt = idx_inc;
      y_nxt = ONE << idx_inc;
      wrap_nxt = idx_inc == '0;
    end
`ifdef DEC_SCAN_BLANK_EN
    else if (cnt == LAST) begin
      y_nxt = '0;
      cnt_nxt = BLANK;
    end
`endif
    else
      cnt_nxt = cnt + 1'b1;
  end
endmodule

// File: tb/tb_decoder_scan_seq.sv
// tb_decoder_scan_seq: directed and random checks of decoder_scan_seq using an expected-value queue.
module tb_decoder_scan_seq;
  localparam int N = 3;
  localparam int OUTW = 8;
`ifdef DEC_SCAN_BLANK_EN
  localparam int HOLD = 2;
  localparam int BL = 1;
`else
  localparam int HOLD = 4;
  localparam int BL = 0;
`endif
  localparam int S = HOLD + BL;
  localparam int P = S * OUTW;
  typedef struct {logic [OUTW-1:0] y; logic [N-1:0] idx; logic wrap;} exp_t;
  logic clk = 0, rst_n = 0, en = 0, mode = 0, x_valid = 0;
  logic x_ready, wrap;
  logic [N-1:0] x_in = '0, idx;
  logic [OUTW-1:0] y;
  logic [OUTW-1:0] one = 1;
  logic pen, pmode, pval;
  logic [N-1:0] px, pidx;
  logic [OUTW-1:0] py;
  exp_t sb[$];
  int total = 0, passed = 0, fails = 0;
  always #5 clk = ~clk;
  decoder_scan_seq #(.N(N), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x_in(x_in),
    .x_valid(x_valid), .x_ready(x_ready), .y(y), .idx(idx), .wrap(wrap)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_next(input logic [OUTW-1:0] ey, input logic [N-1:0] ei, input logic ew);
    sb.push_back('{ey, ei, ew});
  endtask
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("y", y, e.y);
      chk("idx", idx, e.idx);
      chk("wrap", wrap, e.wrap);
    end
  endtask
  // Scan timeline from entry at line start: HOLD active cycles (+ optional blank) per line.
  task automatic scan_run(input int start, input int n);
    for (int p = 0; p < n; p++) begin
      int line = (start + p / S) % OUTW;
      int w = p % S;
      expect_next(w < HOLD ? one << line : '0, N'(line), p > 0 && w == 0 && line == 0);
      cyc();
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #1;
    chk("rst_y", y, 0);
    chk("rst_idx", idx, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_ready", x_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    expect_next('0, 0, 0);
    cyc();
    en = 1; mode = 0; x_in = 5; x_valid = 1;
    #1 chk("dir_ready", x_ready, 1);
    expect_next(8'h20, 5, 0);
    cyc();
    x_in = 0;
    expect_next(8'h01, 0, 0);
    cyc();
    x_valid = 0; x_in = 7;
    expect_next(8'h01, 0, 0);
    cyc();
    mode = 1; x_valid = 1; x_in = 6;
    #1 chk("scan_ready", x_ready, 0);
    scan_run(0, P + 3 * S + 2);
    en = 0;
    expect_next('0, 3, 0);
    cyc();
    expect_next('0, 3, 0);
    cyc();
    en = 1;
    scan_run(3, S + 1);
    mode = 0; x_valid = 0;
    #1 chk("switch_ready", x_ready, 1);
    expect_next(8'h10, 4, 0);
    cyc();
    en = 0; x_valid = 1; x_in = 2;
    #1 chk("idle_ready", x_ready, 0);
    expect_next('0, 4, 0);
    cyc();
    en = 1; x_valid = 0;
    expect_next('0, 4, 0);
    cyc();
    x_valid = 1; x_in = 7;
    expect_next(8'h80, 7, 0);
    cyc();
    x_in = 2;
    expect_next(8'h04, 2, 0);
    cyc();
    x_in = 7;
    expect_next(8'h80, 7, 0);
    cyc();
    x_valid = 0; mode = 1;
    scan_run(7, S + 2);
    #2 rst_n = 0;
    #1;
    chk("arst_y", y, 0);
    chk("arst_idx", idx, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_ready", x_ready, 0);
    @(posedge clk);
    #1 rst_n = 1;
    scan_run(0, S + 2);
    for (int i = 0; i < 10000; i++) begin
      pen = en; pmode = mode; pval = x_valid; px = x_in; py = y; pidx = idx;
      @(posedge clk);
      #1;
      chk("onehot", $countones(y) <= 1, 1);
      if (!pen)
        chk("rnd_idle_y", y, 0);
      else if (!pmode) begin
        chk("rnd_dir_y", y, pval ? one << px : py);
        chk("rnd_dir_idx", idx, pval ? px : pidx);
      end
      en = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      x_valid = $urandom_range(0, 1) == 1;
      x_in = N'($urandom_range(0, OUTW - 1));
      #1 chk("rnd_ready", x_ready, en & ~mode);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
